block_sum_accum: RTL and testbench
==================================

BLOCK_SUM_ACCUM -- requirements
Module: block_sum_accum

Interface
REQ-001 Parameter: BLOCK_PIX, default 4096, number of pixel beats per block (range 1..65535).
REQ-002 Parameter: SUM_W, default 14, width of each sum output.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: blk_clr  input  1  abort current block, clear sums and beat count.
REQ-006 Port: in_valid  input  1  pixel beat offered.
REQ-007 Port: in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 Port: pix_f, pix_g, pix_w  input  1 each  binary left-eye pixel, right-eye pixel, window weight.
REQ-009 Port: out_valid  output  1  block sums are stable and valid.
REQ-010 Port: out_ready  input  1  consumer takes the sums when out_valid && out_ready.
REQ-011 Port: wf, f2sum, g2sum, wg, wfg, fg  output  SUM_W each  block sums of w*f, f*f, g*g, w*g, w*f*g, f*g, matching the distance-formula consumer's inputs.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM and HOLD.
REQ-013 IDLE: in_ready=1; the first accepted beat SHALL be summed and move the FSM to ACCUM (or HOLD if BLOCK_PIX=1).
REQ-014 ACCUM: in_ready=1; each accepted beat SHALL add its six products to the sums and increment a 16-bit beat counter.
REQ-015 The beat that makes the counter equal BLOCK_PIX SHALL move the FSM to HOLD; out_valid SHALL rise the cycle after that beat is accepted (latency 1).
REQ-016 HOLD: in_ready=0, out_valid=1, and the sums SHALL be held constant until out_ready=1.
REQ-017 A HOLD cycle with out_ready=1 SHALL clear the sums and counter and return the FSM to IDLE; in_ready SHALL be 1 on the following cycle.
REQ-018 Cycles with in_valid=0 SHALL leave the state and sums unchanged.
REQ-019 blk_clr=1 in any state SHALL clear the sums and counter, drop out_valid, and return the FSM to IDLE next cycle.
REQ-020 If blk_clr and an accepted beat coincide, the beat SHALL be discarded.
REQ-021 If blk_clr and an out_ready handshake coincide, the result is discarded and clr semantics apply.
REQ-022 Each sum update SHALL be at most +1 per beat; arithmetic behaviour at 2^SUM_W-1 is set by REQ-026.

Reset
REQ-023 While rst_n=0 at a clock edge: state=IDLE, all six sums=0, counter=0, out_valid=0, in_ready=0.
REQ-024 in_ready SHALL be 1 in the first cycle after rst_n returns high; a reset mid-block SHALL discard all partial sums.

Configuration
REQ-025 The macro ACCUM_SAT_EN SHALL select the overflow behaviour of the sums.
REQ-026 With ACCUM_SAT_EN defined, each sum SHALL saturate at 2^SUM_W-1; without it, each sum SHALL wrap modulo 2^SUM_W.

Structure
REQ-027 The shared package eye_dist_pkg SHALL hold SUM_W=14, RES_W=19, and a typedef for the six-sum bundle used by both producer and consumer.
REQ-028 One sub-module, sat_acc, SHALL implement a single SUM_W accumulator (clear, increment, saturation per ACCUM_SAT_EN); it SHALL be instantiated six times.

Verification
REQ-029 Basic block: BLOCK_PIX=4, beats (f,g,w) = (1,1,1),(1,0,0),(0,1,1),(1,1,0) -> f2sum=3, g2sum=3, wf=1, wg=2, fg=2, wfg=1; out_valid rises 1 cycle after the 4th beat.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0 and sums constant; then out_ready=1 for one cycle -> IDLE, sums 0, in_ready=1 on the next cycle.
REQ-031 Gaps: same beats as REQ-029 with in_valid toggling every cycle -> identical sums, out_valid after the 4th accepted beat.
REQ-032 Abort: blk_clr coincident with the 3rd beat of a 4-beat block -> sums 0, IDLE; the next 4 beats alone form the block.
REQ-033 Overflow: BLOCK_PIX=20000, all inputs 1 -> every sum = 16383 with ACCUM_SAT_EN, and 3616 without it.
REQ-034 Reset mid-block: rst_n=0 for one cycle after 2 beats -> all outputs 0; the following block of 4 beats is counted from zero.

Source files
------------

// File: rtl/eye_dist_pkg.sv
// eye_dist_pkg: widths, FSM states and the six-sum bundle
// shared by the block sum producer and the distance consumer.
package eye_dist_pkg;

  localparam int SUM_W = 14;
  localparam int RES_W = 19;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  typedef struct packed {
    logic [SUM_W-1:0] wf;
    logic [SUM_W-1:0] f2sum;
    logic [SUM_W-1:0] g2sum;
    logic [SUM_W-1:0] wg;
    logic [SUM_W-1:0] wfg;
    logic [SUM_W-1:0] fg;
  } sums_t;

  // Binary products, bit order matches sums_t field order
  // (bit 5 = wf ... bit 0 = fg).
  function automatic logic [5:0] products(
    input logic f,
    input logic g,
    input logic w
  );
    return {w & f, f, g, w & g, w & f & g, f & g};
  endfunction

endpackage

// File: rtl/block_sum_accum_if.sv
// block_sum_accum_if: pixel-beat input handshake plus block-sum
// output handshake. master = producer/consumer side, slave = block.
interface block_sum_accum_if #(
  parameter int SUM_W = 14
);

  logic             in_valid;
  logic             in_ready;
  logic             pix_f;
  logic             pix_g;
  logic             pix_w;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] wf;
  logic [SUM_W-1:0] f2sum;
  logic [SUM_W-1:0] g2sum;
  logic [SUM_W-1:0] wg;
  logic [SUM_W-1:0] wfg;
  logic [SUM_W-1:0] fg;

  modport master (
    output in_valid, pix_f, pix_g, pix_w, out_ready,
    input  in_ready, out_valid,
    input  wf, f2sum, g2sum, wg, wfg, fg
  );

  modport slave (
    input  in_valid, pix_f, pix_g, pix_w, out_ready,
    output in_ready, out_valid,
    output wf, f2sum, g2sum, wg, wfg, fg
  );

endinterface

// File: rtl/sat_acc.sv
// sat_acc: one W-bit +1 accumulator with clear (clear wins).
// ACCUM_SAT_EN: saturate at all-ones; otherwise wrap mod 2^W.
module sat_acc #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i) begin
`ifdef ACCUM_SAT_EN
      if (q_q != {W{1'b1}}) begin
        q_d = q_q + 1'b1;
      end
`else
      q_d = q_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/block_sum_accum.sv
// block_sum_accum: sums six binary pixel products over BLOCK_PIX
// beats, holds them until taken. Ports: clk, rst_n (sync, low),
// blk_clr, bus (block_sum_accum_if.slave). Macro: ACCUM_SAT_EN.
module block_sum_accum
  import eye_dist_pkg::*;
#(
  parameter int BLOCK_PIX = 4096,
  parameter int SUM_W     = eye_dist_pkg::SUM_W
) (
  input logic               clk,
  input logic               rst_n,
  input logic               blk_clr,
  block_sum_accum_if.slave  bus
);

  localparam logic [CNT_W:0] LAST = (CNT_W+1)'(BLOCK_PIX);

  state_t                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       in_ready_q;
  logic                       out_valid_q;

  logic                       acc;
  logic                       take;
  logic                       clr;
  logic [5:0]                 prod;
  logic [CNT_W:0]             cnt_nx;
  logic [5:0][SUM_W-1:0]      sum;

  // A beat coinciding with blk_clr is dropped.
  assign acc    = bus.in_valid & in_ready_q & ~blk_clr;
  assign take   = (state_q == HOLD) & bus.out_ready;
  assign clr    = blk_clr | take;
  assign prod   = products(bus.pix_f, bus.pix_g, bus.pix_w);
  assign cnt_nx = {1'b0, cnt_q} + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (blk_clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          in_ready_q <= 1'b1;
          if (acc) begin
            cnt_q <= cnt_nx[CNT_W-1:0];
            if (cnt_nx == LAST) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_acc
    sat_acc #(
      .W (SUM_W)
    ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .inc_i (acc & prod[i]),
      .q_o   (sum[i])
    );
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.wf        = sum[5];
  assign bus.f2sum     = sum[4];
  assign bus.g2sum     = sum[3];
  assign bus.wg        = sum[2];
  assign bus.wfg       = sum[1];
  assign bus.fg        = sum[0];

endmodule

// File: tb/tb_block_sum_accum.sv
// tb_block_sum_accum: directed stimulus with a queue scoreboard
// popped on each output handshake; a 4-beat and a 20000-beat DUT.
module tb_block_sum_accum;
  import eye_dist_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  always #5 clk = ~clk;

  block_sum_accum_if #(.SUM_W(SUM_W)) a ();
  block_sum_accum_if #(.SUM_W(SUM_W)) b ();

  block_sum_accum #(
    .BLOCK_PIX (4),
    .SUM_W     (SUM_W)
  ) u_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .blk_clr (clr_a),
    .bus     (a.slave)
  );

  block_sum_accum #(
    .BLOCK_PIX (20000),
    .SUM_W     (SUM_W)
  ) u_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .blk_clr (clr_b),
    .bus     (b.slave)
  );

`ifdef ACCUM_SAT_EN
  localparam int OVF = 16383;
`else
  localparam int OVF = 3616;
`endif

  sums_t qa[$];
  sums_t qb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic sums_t mk(input int wf, input int f2,
                               input int g2, input int wg,
                               input int wfg, input int fg);
    sums_t s;
    s.wf    = SUM_W'(wf);
    s.f2sum = SUM_W'(f2);
    s.g2sum = SUM_W'(g2);
    s.wg    = SUM_W'(wg);
    s.wfg   = SUM_W'(wfg);
    s.fg    = SUM_W'(fg);
    return s;
  endfunction

  function automatic sums_t got_a();
    return {a.wf, a.f2sum, a.g2sum, a.wg, a.wfg, a.fg};
  endfunction

  function automatic sums_t got_b();
    return {b.wf, b.f2sum, b.g2sum, b.wg, b.wfg, b.fg};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // Scoreboard monitors: a handshake coinciding with blk_clr or
  // reset carries no result.
  initial forever begin
    @(negedge clk);
    if (rst_n && a.out_valid && a.out_ready && !clr_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_a unexpected output %0h", got_a());
      end else begin
        chk("sb_a", got_a(), qa.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && b.out_valid && b.out_ready && !clr_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_b unexpected output %0h", got_b());
      end else begin
        chk("sb_b", got_b(), qb.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic f, input logic g, input logic w);
    logic rdy;
    int   n;
    a.pix_f    = f;
    a.pix_g    = g;
    a.pix_w    = w;
    a.in_valid = 1'b1;
    n = 0;
    do begin
      rdy = a.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 20);
    a.in_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout got in_ready 0 exp 1");
    end
  endtask

  task automatic take_a();
    a.out_ready = 1'b1;
    cyc(1);
    a.out_ready = 1'b0;
  endtask

  task automatic basic4();
    beat(1, 1, 1);
    beat(1, 0, 0);
    beat(0, 1, 1);
    chk("basic_ov_early", a.out_valid, 0);
    beat(1, 1, 0);
    chk("basic_ov_lat1", a.out_valid, 1);
  endtask

  initial begin
    int n;
    a.in_valid  = 1'b0;
    a.pix_f     = 1'b0;
    a.pix_g     = 1'b0;
    a.pix_w     = 1'b0;
    a.out_ready = 1'b0;
    b.in_valid  = 1'b0;
    b.pix_f     = 1'b0;
    b.pix_g     = 1'b0;
    b.pix_w     = 1'b0;
    b.out_ready = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_sums", got_a(), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_rel_in_ready", a.in_ready, 1);

    // Basic block
    basic4();
    qa.push_back(mk(1, 3, 3, 2, 1, 2));

    // Backpressure: HOLD ignores offered beats
    a.pix_f    = 1'b1;
    a.pix_g    = 1'b1;
    a.pix_w    = 1'b1;
    a.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("bp_in_ready", a.in_ready, 0);
      chk("bp_sums", got_a(), mk(1, 3, 3, 2, 1, 2));
    end
    a.in_valid = 1'b0;
    take_a();
    chk("take_ov", a.out_valid, 0);
    chk("take_sums", got_a(), 0);
    chk("take_in_ready", a.in_ready, 1);

    // Gaps: idle cycles with live pixel values are ignored
    beat(1, 1, 1);
    a.pix_f = 1'b1; a.pix_g = 1'b1; a.pix_w = 1'b1; cyc(1);
    beat(1, 0, 0);
    a.pix_f = 1'b1; a.pix_g = 1'b1; a.pix_w = 1'b1; cyc(1);
    beat(0, 1, 1);
    a.pix_f = 1'b1; a.pix_g = 1'b1; a.pix_w = 1'b1; cyc(1);
    chk("gap_ov_early", a.out_valid, 0);
    beat(1, 1, 0);
    chk("gap_ov", a.out_valid, 1);
    qa.push_back(mk(1, 3, 3, 2, 1, 2));
    take_a();

    // Abort on the 3rd beat
    beat(1, 1, 1);
    beat(1, 1, 1);
    clr_a = 1'b1;
    beat(1, 1, 1);
    clr_a = 1'b0;
    chk("abort_sums", got_a(), 0);
    chk("abort_ov", a.out_valid, 0);
    chk("abort_in_ready", a.in_ready, 1);
    beat(0, 1, 0);
    beat(1, 1, 1);
    beat(1, 0, 1);
    chk("abort_ov_early", a.out_valid, 0);
    beat(0, 0, 0);
    chk("abort_ov_blk", a.out_valid, 1);
    qa.push_back(mk(2, 2, 2, 1, 1, 1));
    take_a();

    // blk_clr together with the output handshake discards result
    basic4();
    clr_a       = 1'b1;
    a.out_ready = 1'b1;
    cyc(1);
    clr_a       = 1'b0;
    a.out_ready = 1'b0;
    chk("clrtake_ov", a.out_valid, 0);
    chk("clrtake_sums", got_a(), 0);
    chk("clrtake_in_ready", a.in_ready, 1);

    // Reset mid-block
    beat(1, 1, 1);
    beat(1, 1, 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midrst_sums", got_a(), 0);
    chk("midrst_ov", a.out_valid, 0);
    chk("midrst_in_ready", a.in_ready, 0);
    cyc(1);
    chk("midrst_rel_ready", a.in_ready, 1);
    basic4();
    qa.push_back(mk(1, 3, 3, 2, 1, 2));
    take_a();

    // Overflow on the 20000-beat instance
    qb.push_back(mk(OVF, OVF, OVF, OVF, OVF, OVF));
    b.pix_f    = 1'b1;
    b.pix_g    = 1'b1;
    b.pix_w    = 1'b1;
    b.in_valid = 1'b1;
    n = 0;
    while (!b.out_valid && n < 20100) begin
      cyc(1);
      n++;
    end
    b.in_valid = 1'b0;
    chk("ovf_done", b.out_valid, 1);
    chk("ovf_beats", n, 20000);
    b.out_ready = 1'b1;
    cyc(1);
    b.out_ready = 1'b0;
    chk("ovf_take_ov", b.out_valid, 0);
    chk("ovf_take_sums", got_b(), 0);

    cyc(2);
    chk("sb_a_drained", qa.size(), 0);
    chk("sb_b_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
